// File: rtl/clint_pkg_ysyx_23060136.sv
// Shared CLINT definitions: register offsets, response codes, FSM state types and decode result.
package clint_pkg_ysyx_23060136;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOTA,
        W_GOTD,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_MTIME
    } reg_sel_t;

    typedef struct packed {
        reg_sel_t   sel;
        logic [3:0] hart;
        logic       hi_lane;
    } dec_t;

    // Byte-lane merge used for every strobed 64-bit register update.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_dat,
                                               input logic [63:0] new_dat,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_dat;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_dat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_mtime_cnt_ysyx_23060136.sv
// Prescaled free-running 64-bit mtime; strobed load replaces the increment in its cycle.
// Load takes effect on the next edge; no backpressure, the counter never stalls.
module clint_mtime_cnt_ysyx_23060136
    import clint_pkg_ysyx_23060136::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [63:0] ld_dat,
    input  logic [7:0]  ld_strb,
    output logic [63:0] mtime_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        mtime_d = mtime_q;
        // Prescaler keeps running across a load so the tick phase is undisturbed.
        if (ld_vld) begin
            mtime_d = strb_merge(mtime_q, ld_dat, ld_strb);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_mtimer_ysyx_23060136.sv
// CLINT: mtime, per-hart mtimecmp/msip behind an AXI-lite style slave; read latency 1 cycle,
// write commits on the edge that captures the last of addr/data; responses held until accepted.
module clint_mtimer_ysyx_23060136
    import clint_pkg_ysyx_23060136::*;
#(
    parameter int          NHARTS     = 1,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter int          TICK_DIV   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       CLINT_MEM_raddr,
    input  logic [2:0]        CLINT_MEM_rsize,
    input  logic              CLINT_MEM_raddr_valid,
    output logic              CLINT_MEM_raddr_ready,
    output logic [63:0]       CLINT_MEM_rdata,
    output logic [1:0]        CLINT_MEM_rresp,
    output logic              CLINT_MEM_rdata_valid,
    input  logic              CLINT_MEM_rdata_ready,
    input  logic [31:0]       CLINT_MEM_waddr,
    input  logic              CLINT_MEM_waddr_valid,
    output logic              CLINT_MEM_waddr_ready,
    input  logic [63:0]       CLINT_MEM_wdata,
    input  logic [7:0]        CLINT_MEM_wstrb,
    input  logic              CLINT_MEM_wdata_valid,
    output logic              CLINT_MEM_wdata_ready,
    output logic [1:0]        CLINT_MEM_bresp,
    output logic              CLINT_MEM_bvalid,
    input  logic              CLINT_MEM_bready,
    output logic [NHARTS-1:0] mtip_o,
    output logic [NHARTS-1:0] msip_o
);

    rd_state_t   rd_state_q, rd_state_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    wr_state_t   wr_state_q, wr_state_d;
    logic [31:0] waddr_q, waddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [63:0]       mtimecmp_q [NHARTS];
    logic [63:0]       mtimecmp_d [NHARTS];
    logic [NHARTS-1:0] msip_q, msip_d;
    logic [NHARTS-1:0] mtip_q, mtip_d;

    logic [63:0] mtime;
    logic        mtime_ld;
    dec_t        rd_dec, wr_dec;
    logic [63:0] rd_val;
    logic [31:0] wr_addr;
    logic [63:0] wr_dat;
    logic [7:0]  wr_strb;
    logic        aw_hs, w_hs, commit;
    logic        unused_rsize;

    assign unused_rsize = ^CLINT_MEM_rsize;

    // Only exact, naturally aligned register offsets decode; everything else is DECERR.
    function automatic dec_t decode(input logic [31:0] addr);
        logic [31:0] off;
        dec_t        d;
        off       = addr - CLINT_BASE;
        d.sel     = SEL_NONE;
        d.hart    = '0;
        d.hi_lane = 1'b0;
        if (off[31:16] == 16'd0) begin
            if (((off[15:0] - MSIP_OFF) < 16'(4 * NHARTS)) && (off[1:0] == 2'b00)) begin
                d.sel     = SEL_MSIP;
                d.hart    = off[5:2];
                d.hi_lane = off[2];
            end else if ((off[15:0] >= MTIMECMP_OFF) &&
                         (off[15:0] < (MTIMECMP_OFF + 16'(8 * NHARTS))) &&
                         (off[2:0] == 3'b000)) begin
                d.sel  = SEL_MTIMECMP;
                d.hart = off[6:3];
            end else if (off[15:0] == MTIME_OFF) begin
                d.sel = SEL_MTIME;
            end
        end
        return d;
    endfunction

    clint_mtime_cnt_ysyx_23060136 #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime_cnt (
        .clk     (clk),
        .rst     (rst),
        .ld_vld  (mtime_ld),
        .ld_dat  (wr_dat),
        .ld_strb (wr_strb),
        .mtime_o (mtime)
    );

    assign rd_dec = decode(CLINT_MEM_raddr);

    always_comb begin
        rd_val = '0;
        case (rd_dec.sel)
            SEL_MSIP: begin
                for (int h = 0; h < NHARTS; h++) begin
                    if (rd_dec.hart == 4'(h)) begin
                        rd_val = rd_dec.hi_lane ? {31'd0, msip_q[h], 32'd0} : {63'd0, msip_q[h]};
                    end
                end
            end
            SEL_MTIMECMP: begin
                for (int h = 0; h < NHARTS; h++) begin
                    if (rd_dec.hart == 4'(h)) begin
                        rd_val = mtimecmp_q[h];
                    end
                end
            end
            SEL_MTIME: rd_val = mtime;
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (CLINT_MEM_raddr_valid) begin
                    rdata_d    = rd_val;
                    rresp_d    = (rd_dec.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (CLINT_MEM_rdata_ready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign CLINT_MEM_raddr_ready = (rd_state_q == R_IDLE);
    assign CLINT_MEM_rdata_valid = (rd_state_q == R_RESP);
    assign CLINT_MEM_rdata       = rdata_q;
    assign CLINT_MEM_rresp       = rresp_q;

    assign CLINT_MEM_waddr_ready = (wr_state_q == W_IDLE) || (wr_state_q == W_GOTD);
    assign CLINT_MEM_wdata_ready = (wr_state_q == W_IDLE) || (wr_state_q == W_GOTA);
    assign CLINT_MEM_bvalid      = (wr_state_q == W_RESP);
    assign CLINT_MEM_bresp       = bresp_q;

    assign aw_hs = CLINT_MEM_waddr_valid && CLINT_MEM_waddr_ready;
    assign w_hs  = CLINT_MEM_wdata_valid && CLINT_MEM_wdata_ready;

    // The commit uses whichever half was captured earlier plus the beat arriving now.
    always_comb begin
        wr_addr = (wr_state_q == W_GOTA) ? waddr_q : CLINT_MEM_waddr;
        wr_dat  = (wr_state_q == W_GOTD) ? wdata_q : CLINT_MEM_wdata;
        wr_strb = (wr_state_q == W_GOTD) ? wstrb_q : CLINT_MEM_wstrb;
    end

    assign wr_dec = decode(wr_addr);

    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    waddr_d    = CLINT_MEM_waddr;
                    wr_state_d = W_GOTA;
                end else if (w_hs) begin
                    wdata_d    = CLINT_MEM_wdata;
                    wstrb_d    = CLINT_MEM_wstrb;
                    wr_state_d = W_GOTD;
                end
            end
            W_GOTA: commit = w_hs;
            W_GOTD: commit = aw_hs;
            W_RESP: begin
                if (CLINT_MEM_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (commit) begin
            wr_state_d = W_RESP;
            bresp_d    = (wr_dec.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
        end
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_ld   = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            mtip_d[h] = (mtime >= mtimecmp_q[h]);
        end
        if (commit) begin
            case (wr_dec.sel)
                SEL_MSIP: begin
                    for (int h = 0; h < NHARTS; h++) begin
                        if ((wr_dec.hart == 4'(h)) && wr_strb[{wr_dec.hi_lane, 2'b00}]) begin
                            msip_d[h] = wr_dat[{wr_dec.hi_lane, 5'b00000}];
                        end
                    end
                end
                SEL_MTIMECMP: begin
                    for (int h = 0; h < NHARTS; h++) begin
                        if (wr_dec.hart == 4'(h)) begin
                            mtimecmp_d[h] = strb_merge(mtimecmp_q[h], wr_dat, wr_strb);
                        end
                    end
                end
                SEL_MTIME: mtime_ld = 1'b1;
                default:   mtime_ld = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_state_q <= W_IDLE;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            msip_q     <= '0;
            mtip_q     <= '0;
            for (int h = 0; h < NHARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            for (int h = 0; h < NHARTS; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign mtip_o = mtip_q;
    assign msip_o = msip_q;

endmodule

// File: tb/tb_clint_mtimer_ysyx_23060136.sv
// Randomized scoreboard bench for the CLINT against a transaction-level reference model.
module tb_clint_mtimer_ysyx_23060136;

    localparam int          NH   = 2;
    localparam int          TD   = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic          clk, rst;
    logic [31:0]   raddr;
    logic [2:0]    rsize;
    logic          raddr_valid, raddr_ready;
    logic [63:0]   rdata;
    logic [1:0]    rresp;
    logic          rdata_valid, rdata_ready;
    logic [31:0]   waddr;
    logic          waddr_valid, waddr_ready;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
    logic          wdata_valid, wdata_ready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [NH-1:0] mtip, msip;

    clint_mtimer_ysyx_23060136 #(
        .NHARTS     (NH),
        .CLINT_BASE (BASE),
        .TICK_DIV   (TD)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .CLINT_MEM_raddr       (raddr),
        .CLINT_MEM_rsize       (rsize),
        .CLINT_MEM_raddr_valid (raddr_valid),
        .CLINT_MEM_raddr_ready (raddr_ready),
        .CLINT_MEM_rdata       (rdata),
        .CLINT_MEM_rresp       (rresp),
        .CLINT_MEM_rdata_valid (rdata_valid),
        .CLINT_MEM_rdata_ready (rdata_ready),
        .CLINT_MEM_waddr       (waddr),
        .CLINT_MEM_waddr_valid (waddr_valid),
        .CLINT_MEM_waddr_ready (waddr_ready),
        .CLINT_MEM_wdata       (wdata),
        .CLINT_MEM_wstrb       (wstrb),
        .CLINT_MEM_wdata_valid (wdata_valid),
        .CLINT_MEM_wdata_ready (wdata_ready),
        .CLINT_MEM_bresp       (bresp),
        .CLINT_MEM_bvalid      (bvalid),
        .CLINT_MEM_bready      (bready),
        .mtip_o                (mtip),
        .msip_o                (msip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];

    // Reference state: architectural values only, advanced once per clock edge.
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip, m_mtip;
    int unsigned   m_cycles;
    bit            m_live = 0;
    bit            a_done, d_done;
    logic [31:0]   m_waddr;
    logic [63:0]   m_wdata;
    logic [7:0]    m_wstrb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=no_event required=event_within_50_cycles t=%0t", name, $time);
    endtask

    function automatic rexp_t ref_read(input logic [31:0] a);
        rexp_t       e;
        logic [31:0] off;
        off = a - BASE;
        e.d = 64'd0;
        e.r = 2'b11;
        for (int h = 0; h < NH; h++) begin
            if (off == 32'(4 * h)) begin
                e.d = {63'd0, m_msip[h]} << (32 * (h % 2));
                e.r = 2'b00;
            end
            if (off == 32'h4000 + 32'(8 * h)) begin
                e.d = m_cmp[h];
                e.r = 2'b00;
            end
        end
        if (off == 32'hBFF8) begin
            e.d = m_mtime;
            e.r = 2'b00;
        end
        return e;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [63:0] wd,
                                      input logic [7:0] ws, output logic [1:0] resp,
                                      output bit mt_wr, output logic [63:0] mt_val);
        logic [31:0] off;
        int          lane;
        off    = a - BASE;
        resp   = 2'b11;
        mt_wr  = 0;
        mt_val = m_mtime;
        for (int h = 0; h < NH; h++) begin
            lane = h % 2;
            if (off == 32'(4 * h)) begin
                resp = 2'b00;
                if (ws[4 * lane]) m_msip[h] = wd[32 * lane];
            end
            if (off == 32'h4000 + 32'(8 * h)) begin
                resp = 2'b00;
                for (int b = 0; b < 8; b++) if (ws[b]) m_cmp[h][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (off == 32'hBFF8) begin
            resp  = 2'b00;
            mt_wr = 1;
            for (int b = 0; b < 8; b++) if (ws[b]) mt_val[8*b +: 8] = wd[8*b +: 8];
        end
    endfunction

    // Reference model: compare interrupt lines, then predict the effect of the coming edge.
    always @(negedge clk) begin
        logic [NH-1:0] nx_mtip;
        logic [1:0]    resp;
        bit            mt_wr, tick;
        logic [63:0]   mt_val;
        if (m_live) begin
            chk("mtip_o", 64'(mtip), 64'(m_mtip));
            chk("msip_o", 64'(msip), 64'(m_msip));
        end
        if (rst) begin
            m_mtime  = 64'd0;
            m_cycles = 0;
            m_msip   = '0;
            m_mtip   = '0;
            for (int h = 0; h < NH; h++) m_cmp[h] = '1;
            a_done = 0;
            d_done = 0;
            rq.delete();
            bq.delete();
            m_live = 1;
        end else if (m_live) begin
            for (int h = 0; h < NH; h++) nx_mtip[h] = (m_mtime >= m_cmp[h]);
            tick = ((m_cycles % TD) == TD - 1);
            if (raddr_valid && raddr_ready) rq.push_back(ref_read(raddr));
            if (waddr_valid && waddr_ready) begin
                m_waddr = waddr;
                a_done  = 1;
            end
            if (wdata_valid && wdata_ready) begin
                m_wdata = wdata;
                m_wstrb = wstrb;
                d_done  = 1;
            end
            mt_wr = 0;
            if (a_done && d_done) begin
                ref_write(m_waddr, m_wdata, m_wstrb, resp, mt_wr, mt_val);
                bq.push_back(resp);
                a_done = 0;
                d_done = 0;
            end
            if (mt_wr)     m_mtime = mt_val;
            else if (tick) m_mtime = m_mtime + 64'd1;
            m_cycles++;
            m_mtip = nx_mtip;
        end
    end

    // Monitor: pops expectations when the DUT presents responses; checks hold-until-accepted.
    bit r_pend = 0, b_pend = 0;
    always @(negedge clk) begin
        if (rst || !m_live) begin
            r_pend = 0;
            b_pend = 0;
        end else begin
            if (r_pend && !rdata_valid) chk("rdata_valid_hold", 64'(rdata_valid), 64'd1);
            if (rdata_valid) begin
                if (rq.size() == 0) chk("rdata_valid_unexpected", 64'(rdata_valid), 64'd0);
                else begin
                    chk("rdata", rdata, rq[0].d);
                    chk("rresp", 64'(rresp), 64'(rq[0].r));
                    if (rdata_ready) void'(rq.pop_front());
                end
                r_pend = !rdata_ready;
            end else r_pend = 0;
            if (b_pend && !bvalid) chk("bvalid_hold", 64'(bvalid), 64'd1);
            if (bvalid) begin
                if (bq.size() == 0) chk("bvalid_unexpected", 64'(bvalid), 64'd0);
                else begin
                    chk("bresp", 64'(bresp), 64'(bq[0]));
                    if (bready) void'(bq.pop_front());
                end
                b_pend = !bready;
            end else b_pend = 0;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly);
        bit hs;
        int n;
        raddr       = a;
        raddr_valid = 1'b1;
        hs = 0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = raddr_ready;
            @(posedge clk);
            #1;
            n++;
        end
        raddr_valid = 1'b0;
        if (!hs) begin
            timeout("raddr_handshake");
            return;
        end
        n = 0;
        while (!rdata_valid && n < 50) begin
            tick_n(1);
            n++;
        end
        if (!rdata_valid) begin
            timeout("rdata_valid");
            return;
        end
        tick_n(rdly);
        rdata_ready = 1'b1;
        tick_n(1);
        rdata_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int lead, input int bdly);
        int n;
        bready = 1'b0;
        fork
            begin
                bit hs;
                int k;
                tick_n(lead > 0 ? lead : 0);
                waddr       = a;
                waddr_valid = 1'b1;
                hs = 0;
                k  = 0;
                while (!hs && k < 50) begin
                    @(negedge clk);
                    hs = waddr_ready;
                    @(posedge clk);
                    #1;
                    k++;
                end
                waddr_valid = 1'b0;
                if (!hs) timeout("waddr_handshake");
            end
            begin
                bit hs;
                int k;
                tick_n(lead < 0 ? -lead : 0);
                wdata       = d;
                wstrb       = s;
                wdata_valid = 1'b1;
                hs = 0;
                k  = 0;
                while (!hs && k < 50) begin
                    @(negedge clk);
                    hs = wdata_ready;
                    @(posedge clk);
                    #1;
                    k++;
                end
                wdata_valid = 1'b0;
                if (!hs) timeout("wdata_handshake");
            end
        join
        n = 0;
        while (!bvalid && n < 50) begin
            tick_n(1);
            n++;
        end
        if (!bvalid) begin
            timeout("bvalid");
            return;
        end
        tick_n(bdly);
        bready = 1'b1;
        tick_n(1);
        bready = 1'b0;
    endtask

    logic [31:0] ofs_tab [12];

    initial begin
        logic [31:0] a;
        logic [63:0] d;
        int          kind;
        ofs_tab = '{32'h0, 32'h4, 32'h2, 32'h8, 32'h4000, 32'h4008,
                    32'h4004, 32'h4010, 32'hBFF8, 32'hBFFC, 32'h8000, 32'h0};
        rst = 1'b1;
        raddr = '0; rsize = 3'd3; raddr_valid = 0; rdata_ready = 0;
        waddr = '0; waddr_valid = 0; wdata = '0; wstrb = '0; wdata_valid = 0; bready = 0;
        tick_n(3);

        @(negedge clk);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_raddr_ready", 64'(raddr_ready), 64'd1);
        chk("rst_waddr_ready", 64'(waddr_ready), 64'd1);
        chk("rst_wdata_ready", 64'(wdata_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tick_n(10);
        do_read(BASE + 32'hBFF8, 0);
        do_read(BASE + 32'h4000, 0);

        do_write(BASE + 32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 0);
        do_read(BASE + 32'hBFF8, 0);
        tick_n(8);
        do_read(BASE + 32'hBFF8, 0);

        do_write(BASE + 32'h4000, m_mtime + 64'd5, 8'hFF, 0, 0);
        tick_n(30);
        chk("mtip0_after_cmp", 64'(mtip[0]), 64'd1);
        do_write(BASE + 32'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        tick_n(2);
        chk("mtip0_after_clear", 64'(mtip[0]), 64'd0);

        do_write(BASE + 32'h4, 64'h0000_0001_0000_0000, 8'hF0, 0, 0);
        tick_n(1);
        chk("msip_hart1", 64'(msip), 64'd2);
        do_read(BASE + 32'h4, 0);
        do_write(BASE + 32'h4, 64'h0, 8'h0F, 0, 0);
        do_read(BASE + 32'h4, 0);
        do_read(BASE + 32'h0, 0);

        do_write(BASE + 32'h4008, 64'h1234_5678_9ABC_DEF0, 8'hFF, 3, 5);
        do_read(BASE + 32'h4008, 0);
        do_write(BASE + 32'h4008, 64'hA5A5_A5A5_5A5A_5A5A, 8'h3C, -2, 1);
        do_read(BASE + 32'h4008, 0);

        do_read(BASE + 32'h8000, 4);
        do_write(BASE + 32'hBFFC, 64'hDEAD_BEEF_0000_0000, 8'hFF, 0, 0);

        fork
            do_read(BASE + 32'h4008, 0);
            do_write(BASE + 32'h4008, 64'h0BAD_F00D_0000_0001, 8'hFF, 0, 0);
        join
        do_read(BASE + 32'h4008, 0);

        repeat (80) begin
            a    = BASE + ofs_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) a = $urandom;
            d    = {$urandom, $urandom};
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_read(a, $urandom_range(0, 3));
            end else if (kind == 1) begin
                do_write(a, d, 8'($urandom), int'($urandom_range(0, 6)) - 3, $urandom_range(0, 3));
            end else begin
                fork
                    do_read(a, $urandom_range(0, 2));
                    do_write(a, d, 8'($urandom), int'($urandom_range(0, 4)) - 2, $urandom_range(0, 2));
                join
            end
            tick_n($urandom_range(0, 3));
        end

        tick_n(5);
        chk("pending_expectations", 64'(rq.size() + bq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
